// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one combinational half-precision adder between two
// requesters; operands are held for FPU_LAT cycles before the result is captured.
module fpu_arbiter #(
  parameter int unsigned FPU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [15:0] fpu_a,
  output logic [15:0] fpu_b,
  input  logic [15:0] fpu_r,
  output logic [15:0] res,
  output logic        res_id,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [3:0] LAT = 4'(FPU_LAT);

  state_t     state, state_d;
  logic [3:0] cnt;
  logic       last;
  logic       win, win_d;
  logic       grant;

  always_comb begin
    state_d = state;
    grant   = 1'b0;
    win_d   = win;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant   = 1'b1;
          // On a tie the requester not served last wins.
          win_d   = (req0 && req1) ? ~last : req1;
          state_d = ISSUE;
        end
      end
      ISSUE:   if (cnt == 4'd1) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      win       <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      res       <= '0;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_d;
      win   <= win_d;
      busy  <= (state_d != IDLE);
      gnt0  <= grant & ~win_d;
      gnt1  <= grant & win_d;
      if (grant) begin
        fpu_a <= win_d ? a1 : a0;
        fpu_b <= win_d ? b1 : b0;
        cnt   <= LAT;
        last  <= win_d;
      end
      if (state == ISSUE) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          res       <= fpu_r;
          res_id    <= win;
          res_valid <= 1'b1;
        end
      end
      if (state == DONE && res_ready) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: one instance at FPU_LAT=1, one at FPU_LAT=3,
// each fed by a lookup-table adder model for the operand pairs used.
module tb_fpu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, res_ready;
  logic [15:0] a0, b0, a1, b1;

  logic        gnt0, gnt1, res_id, res_valid, busy;
  logic [15:0] fpu_a, fpu_b, fpu_r, res;
  logic        gnt0_3, gnt1_3, res_id_3, res_valid_3, busy_3;
  logic [15:0] fpu_a_3, fpu_b_3, fpu_r_3, res_3;

  int vectors = 0;
  int miscompares = 0;

  fpu_arbiter #(.FPU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_r(fpu_r),
    .res(res), .res_id(res_id), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy)
  );

  fpu_arbiter #(.FPU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0_3), .gnt1(gnt1_3), .fpu_a(fpu_a_3), .fpu_b(fpu_b_3), .fpu_r(fpu_r_3),
    .res(res_3), .res_id(res_id_3), .res_valid(res_valid_3), .res_ready(res_ready),
    .busy(busy_3)
  );

  // Half-precision sums for the operand pairs used here; anything else yields NaN.
  function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
    case ({x, y})
      {16'h3C00, 16'h4000}: fadd = 16'h4200;
      {16'hC000, 16'h3C00}: fadd = 16'hBC00;
      {16'h4000, 16'h4000}: fadd = 16'h4400;
      {16'h3C00, 16'h3C00}: fadd = 16'h4000;
      {16'h0000, 16'h0000}: fadd = 16'h0000;
      default:              fadd = 16'h7E00;
    endcase
  endfunction

  always_comb fpu_r   = fadd(fpu_a, fpu_b);
  always_comb fpu_r_3 = fadd(fpu_a_3, fpu_b_3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; res_ready = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #3;
    vectors++;
    if ({gnt0, gnt1, res_valid, res_id, busy, fpu_a, fpu_b, res} !== 53'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {gnt0, gnt1, res_valid, res_id, busy, fpu_a, fpu_b, res});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({gnt0, gnt1, res_valid, busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_idle: got %b expected 0000", {gnt0, gnt1, res_valid, busy});
    end
  endtask

  task automatic test_single;
    req0 = 1; a0 = 16'h3C00; b0 = 16'h4000; res_ready = 1;
    tick();
    vectors++;
    if ({gnt0, gnt1, busy, res_valid, fpu_a, fpu_b} !== {4'b1010, 16'h3C00, 16'h4000}) begin
      miscompares++;
      $display("FAIL single_grant: got %b %h %h expected 1010 3c00 4000",
               {gnt0, gnt1, busy, res_valid}, fpu_a, fpu_b);
    end
    req0 = 0;
    tick();
    vectors++;
    if ({gnt0, res_valid, res_id, res} !== {3'b010, 16'h4200}) begin
      miscompares++;
      $display("FAIL single_result: got gnt0=%b v=%b id=%b res=%h expected 0 1 0 4200",
               gnt0, res_valid, res_id, res);
    end
    tick();
    vectors++;
    if ({res_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_release: got v=%b busy=%b expected 0 0", res_valid, busy);
    end
  endtask

  task automatic test_tie;
    do_reset();
    req0 = 1; req1 = 1; res_ready = 1;
    a0 = 16'h3C00; b0 = 16'h4000; a1 = 16'hC000; b1 = 16'h3C00;
    tick();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin
      miscompares++;
      $display("FAIL tie_first_grant: got %b expected 10", {gnt0, gnt1});
    end
    tick();
    vectors++;
    if ({res_valid, res_id, res} !== {2'b10, 16'h4200}) begin
      miscompares++;
      $display("FAIL tie_first_result: got v=%b id=%b res=%h expected 1 0 4200",
               res_valid, res_id, res);
    end
    tick();
    tick();
    vectors++;
    if ({gnt0, gnt1, fpu_a, fpu_b} !== {2'b01, 16'hC000, 16'h3C00}) begin
      miscompares++;
      $display("FAIL tie_second_grant: got %b %h %h expected 01 c000 3c00",
               {gnt0, gnt1}, fpu_a, fpu_b);
    end
    req0 = 0; req1 = 0;
    tick();
    vectors++;
    if ({res_valid, res_id, res} !== {2'b11, 16'hBC00}) begin
      miscompares++;
      $display("FAIL tie_signed_result: got v=%b id=%b res=%h expected 1 1 bc00",
               res_valid, res_id, res);
    end
    tick();
  endtask

  task automatic test_backpressure;
    req0 = 1; a0 = 16'h4000; b0 = 16'h4000; res_ready = 0;
    tick();
    vectors++;
    if (gnt0 !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_grant: got gnt0=%b expected 1", gnt0);
    end
    req0 = 0; req1 = 1; a1 = 16'h3C00; b1 = 16'h3C00;
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({res_valid, res_id, busy, gnt1, res} !== {4'b1010, 16'h4400}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%b busy=%b gnt1=%b res=%h expected 1 0 1 0 4400",
                 i, res_valid, res_id, busy, gnt1, res);
      end
      tick();
    end
    res_ready = 1;
    #1;
    tick();
    vectors++;
    if ({res_valid, gnt1} !== 2'b00) begin
      miscompares++;
      $display("FAIL bp_transfer: got v=%b gnt1=%b expected 0 0", res_valid, gnt1);
    end
    tick();
    vectors++;
    if (gnt1 !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_req1_grant: got gnt1=%b expected 1", gnt1);
    end
    req1 = 0;
    tick();
    vectors++;
    if ({res_valid, res_id, res} !== {2'b11, 16'h4000}) begin
      miscompares++;
      $display("FAIL bp_req1_result: got v=%b id=%b res=%h expected 1 1 4000",
               res_valid, res_id, res);
    end
    tick();
  endtask

  task automatic test_latency;
    do_reset();
    req0 = 1; a0 = 16'h3C00; b0 = 16'h4000; res_ready = 1;
    tick();
    vectors++;
    if ({gnt0_3, res_valid_3, fpu_a_3, fpu_b_3} !== {2'b10, 16'h3C00, 16'h4000}) begin
      miscompares++;
      $display("FAIL lat_grant: got gnt0=%b v=%b %h %h expected 1 0 3c00 4000",
               gnt0_3, res_valid_3, fpu_a_3, fpu_b_3);
    end
    req0 = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if ({res_valid_3, fpu_a_3, fpu_b_3} !== {(i == 3), 16'h3C00, 16'h4000}) begin
        miscompares++;
        $display("FAIL lat_edge[%0d]: got v=%b %h %h expected %b 3c00 4000",
                 i, res_valid_3, fpu_a_3, fpu_b_3, (i == 3));
      end
    end
    vectors++;
    if ({res_id_3, res_3} !== {1'b0, 16'h4200}) begin
      miscompares++;
      $display("FAIL lat_result: got id=%b res=%h expected 0 4200", res_id_3, res_3);
    end
    tick();
    vectors++;
    if ({res_valid_3, busy_3} !== 2'b00) begin
      miscompares++;
      $display("FAIL lat_release: got v=%b busy=%b expected 0 0", res_valid_3, busy_3);
    end
  endtask

  task automatic test_reset_mid_issue;
    req0 = 1; a0 = 16'h3C00; b0 = 16'h4000; res_ready = 1;
    tick();
    req0 = 0;
    tick();
    vectors++;
    if ({busy_3, res_valid_3} !== 2'b10) begin
      miscompares++;
      $display("FAIL mid_issue_state: got busy=%b v=%b expected 1 0", busy_3, res_valid_3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt0_3, gnt1_3, res_valid_3, res_id_3, busy_3, fpu_a_3, fpu_b_3, res_3} !== 53'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected 0",
               {gnt0_3, gnt1_3, res_valid_3, res_id_3, busy_3, fpu_a_3, fpu_b_3, res_3});
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({res_valid_3, gnt0_3, gnt1_3, busy_3} !== 4'b0000) begin
        miscompares++;
        $display("FAIL post_reset_quiet[%0d]: got %b expected 0000",
                 i, {res_valid_3, gnt0_3, gnt1_3, busy_3});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_latency();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
